// File: rtl/sha_pkg.sv
// -----------------------------------------------------------------------------
// sha_pkg
// Shared types and constants for the SHA core and its downstream result
// checker.
//   HashState      : final SHA state {a,b,c,d,e,f,g,h}, packed so that it
//                    lines up bit-for-bit with a 256-bit doublehash bus.
//   ResultEntry    : one qualifying result, {nonce, epoch}.
//   byte_reverse_256 : turns the doublehash bus into the hash value H
//                    (byte 0 of the bus becomes the most significant byte).
// -----------------------------------------------------------------------------
package sha_pkg;

    localparam int HASH_W         = 256;
    localparam int NONCE_W        = 32;
    localparam int RESULT_EPOCH_W = 8;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] c;
        logic [31:0] d;
        logic [31:0] e;
        logic [31:0] f;
        logic [31:0] g;
        logic [31:0] h;
    } HashState;

    typedef struct packed {
        logic [NONCE_W-1:0]        nonce;
        logic [RESULT_EPOCH_W-1:0] epoch;
    } ResultEntry;

    // The core emits its digest little-endian byte first; the numeric value
    // compared against the target is the byte-reversed word.
    function automatic logic [HASH_W-1:0] byte_reverse_256(input logic [HASH_W-1:0] v);
        logic [HASH_W-1:0] r;
        r = '0;
        for (int k = 0; k < HASH_W / 8; k++) begin
            r[HASH_W-1-8*k -: 8] = v[8*k +: 8];
        end
        return r;
    endfunction

endpackage

// File: rtl/sha_target_expand.sv
// -----------------------------------------------------------------------------
// sha_target_expand
// Purely combinational expansion of a compact difficulty word into a 256-bit
// target. Shared with the host-side model, so it carries no clock or state.
//   difficulty [31:0]  : in,  bits [31:24] exponent E, bits [23:0] mantissa M
//   target     [255:0] : out, expanded target T
// Rules:
//   E > 32       : T = all ones
//   3 <= E <= 32 : T = M << 8*(E-3), truncated to 256 bits
//   E < 3        : T = M >> 8*(3-E)
// The mantissa is unsigned; bit 23 is an ordinary magnitude bit.
// -----------------------------------------------------------------------------
module sha_target_expand (
    input  logic [31:0]  difficulty,
    output logic [255:0] target
);

    logic [7:0]   exponent;
    logic [255:0] mantissa;
    logic [7:0]   shl_bits;
    logic [7:0]   shr_bits;

    always_comb begin
        // NOTE: every signal written here gets a default before any branch, so no path leaves one unassigned and no latch is inferred.
        exponent = difficulty[31:24];
        mantissa = {232'd0, difficulty[23:0]};
        shl_bits = '0;
        shr_bits = '0;
        target   = '0;
        if (exponent > 8'd32) begin
            target = '1;
        end else if (exponent >= 8'd3) begin
            // (E-3)*8 is at most 232, so it fits the 8-bit shift amount.
            shl_bits = (exponent - 8'd3) << 3;
            target   = mantissa << shl_bits;
        end else begin
            shr_bits = (8'd3 - exponent) << 3;
            target   = mantissa >> shr_bits;
        end
    end

endmodule

// File: rtl/sha_result_checker.sv
// -----------------------------------------------------------------------------
// sha_result_checker
// Sits downstream of one pipelined SHA core. Tracks the nonce and block epoch
// of every valid result, compares the byte-reversed double hash against the
// expanded difficulty target, and queues qualifying {nonce, epoch} pairs in a
// small FIFO read out over a valid/ready handshake.
//
// Parameters
//   PROCESSORINDEX : nonce of the first result after a new block
//   NUMPROCESSORS  : nonce stride between consecutive results
//   FIFO_DEPTH     : result FIFO entries (power of two, >= 2)
//
// Ports
//   clk, rst           : clock, asynchronous active-high reset
//   output_valid       : in,  hash inputs valid this cycle
//   newblock_o         : in,  first hash of a new block (qualified by output_valid)
//   doublehash [255:0] : in,  final SHA state {a..h}
//   difficulty [31:0]  : in,  compact target {E, M}
//   result_valid       : out, FIFO head valid
//   result_ready       : in,  consumer takes the head when result_valid is high
//   result_nonce [31:0]: out, nonce of the head entry
//   result_epoch [7:0] : out, epoch of the head entry
//   overflow           : out, one-cycle pulse when a qualifying result is dropped
//   checked_count[31:0]: out, number of valid results seen (wraps)
//
// Pipeline: stage 1 registers H, T, nonce, epoch and valid; the compare and
// the FIFO write happen on the following edge. A result is therefore visible
// at the head two cycles after its output_valid cycle when the FIFO is empty.
// -----------------------------------------------------------------------------
module sha_result_checker
    import sha_pkg::*;
#(
    parameter int PROCESSORINDEX = 0,
    parameter int NUMPROCESSORS  = 1,
    parameter int FIFO_DEPTH     = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      output_valid,
    input  logic                      newblock_o,
    input  logic [255:0]              doublehash,
    input  logic [31:0]               difficulty,
    output logic                      result_valid,
    input  logic                      result_ready,
    output logic [NONCE_W-1:0]        result_nonce,
    output logic [RESULT_EPOCH_W-1:0] result_epoch,
    output logic                      overflow,
    output logic [31:0]               checked_count
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);

    localparam logic [NONCE_W-1:0] FIRST_NONCE  = NONCE_W'(PROCESSORINDEX);
    localparam logic [NONCE_W-1:0] NONCE_STRIDE = NONCE_W'(NUMPROCESSORS);

    // Pointers carry one extra wrap bit to tell full from empty.
    typedef logic [PTR_W:0] ptr_t;
    localparam ptr_t PTR_ONE = ptr_t'(1);

    // ---------------------------------------------------------------------
    // Nonce / epoch tracking
    // ---------------------------------------------------------------------
    logic [RESULT_EPOCH_W-1:0] epoch_q, epoch_d;
    logic [NONCE_W-1:0]        next_nonce_q, next_nonce_d;
    logic [NONCE_W-1:0]        cur_nonce;
    logic [RESULT_EPOCH_W-1:0] cur_epoch;

    always_comb begin
        epoch_d      = epoch_q;
        next_nonce_d = next_nonce_q;
        cur_nonce    = next_nonce_q;
        if (output_valid) begin
            if (newblock_o) begin
                cur_nonce    = FIRST_NONCE;
                next_nonce_d = FIRST_NONCE + NONCE_STRIDE;
                epoch_d      = epoch_q + 8'd1;
            end else begin
                next_nonce_d = next_nonce_q + NONCE_STRIDE;
            end
        end
        // A newblock result already belongs to the new epoch.
        cur_epoch = epoch_d;
    end

    // ---------------------------------------------------------------------
    // Stage 1: byte-reversed hash, expanded target, nonce, epoch
    // ---------------------------------------------------------------------
    logic [255:0] target_expanded;

    sha_target_expand u_target_expand (
        .difficulty (difficulty),
        .target     (target_expanded)
    );

    logic                      s1_valid_q,  s1_valid_d;
    logic [255:0]              s1_hash_q,   s1_hash_d;
    logic [255:0]              s1_target_q, s1_target_d;
    logic [NONCE_W-1:0]        s1_nonce_q,  s1_nonce_d;
    logic [RESULT_EPOCH_W-1:0] s1_epoch_q,  s1_epoch_d;

    always_comb begin
        s1_valid_d  = output_valid;
        s1_hash_d   = s1_hash_q;
        s1_target_d = s1_target_q;
        s1_nonce_d  = s1_nonce_q;
        s1_epoch_d  = s1_epoch_q;
        // Data registers only load on a valid result to keep the wide
        // hash/target flops quiet between results.
        if (output_valid) begin
            s1_hash_d   = byte_reverse_256(doublehash);
            s1_target_d = target_expanded;
            s1_nonce_d  = cur_nonce;
            s1_epoch_d  = cur_epoch;
        end
    end

    // ---------------------------------------------------------------------
    // Stage 2: compare and FIFO write
    // ---------------------------------------------------------------------
    ResultEntry fifo_mem_q [FIFO_DEPTH];
    ResultEntry fifo_mem_d [FIFO_DEPTH];
    ptr_t       wr_ptr_q, wr_ptr_d;
    ptr_t       rd_ptr_q, rd_ptr_d;
    logic       overflow_q, overflow_d;
    logic [31:0] checked_count_q, checked_count_d;

    logic       qualifies;
    logic       fifo_empty;
    logic       fifo_full;
    logic       do_pop;
    logic       do_push;
    logic       drop;
    ResultEntry head;
    ResultEntry new_entry;

    assign qualifies  = s1_valid_q && (s1_hash_q <= s1_target_q);
    assign fifo_empty = (wr_ptr_q == rd_ptr_q);
    assign fifo_full  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                        (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);

    // A pop is only possible on an entry that is already stored; an entry
    // written this edge cannot also leave on it.
    assign do_pop  = !fifo_empty && result_ready;
    // When full, a push only fits if the head leaves on the same edge.
    assign drop    = qualifies && fifo_full && !do_pop;
    assign do_push = qualifies && !drop;

    always_comb begin
        new_entry.nonce = s1_nonce_q;
        new_entry.epoch = s1_epoch_q;

        fifo_mem_d = fifo_mem_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        if (do_push) begin
            fifo_mem_d[wr_ptr_q[PTR_W-1:0]] = new_entry;
            wr_ptr_d                        = wr_ptr_q + PTR_ONE;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end

        overflow_d      = drop;
        checked_count_d = checked_count_q;
        if (output_valid) begin
            checked_count_d = checked_count_q + 32'd1;
        end
    end

    // ---------------------------------------------------------------------
    // State registers
    // ---------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state uses non-blocking assignment so every flop samples pre-edge values regardless of statement order.
        if (rst) begin
            epoch_q         <= '0;
            next_nonce_q    <= FIRST_NONCE;
            s1_valid_q      <= 1'b0;
            s1_hash_q       <= '0;
            s1_target_q     <= '0;
            s1_nonce_q      <= '0;
            s1_epoch_q      <= '0;
            wr_ptr_q        <= '0;
            rd_ptr_q        <= '0;
            overflow_q      <= 1'b0;
            checked_count_q <= '0;
            // NOTE: the FIFO storage is reset as well, so the head outputs read zero out of reset rather than X; affordable at this depth.
            fifo_mem_q      <= '{default: '0};
        end else begin
            epoch_q         <= epoch_d;
            next_nonce_q    <= next_nonce_d;
            s1_valid_q      <= s1_valid_d;
            s1_hash_q       <= s1_hash_d;
            s1_target_q     <= s1_target_d;
            s1_nonce_q      <= s1_nonce_d;
            s1_epoch_q      <= s1_epoch_d;
            wr_ptr_q        <= wr_ptr_d;
            rd_ptr_q        <= rd_ptr_d;
            overflow_q      <= overflow_d;
            checked_count_q <= checked_count_d;
            fifo_mem_q      <= fifo_mem_d;
        end
    end

    // ---------------------------------------------------------------------
    // Outputs
    // ---------------------------------------------------------------------
    assign head          = fifo_mem_q[rd_ptr_q[PTR_W-1:0]];
    assign result_valid  = !fifo_empty;
    assign result_nonce  = head.nonce;
    assign result_epoch  = head.epoch;
    assign overflow      = overflow_q;
    assign checked_count = checked_count_q;

endmodule

// File: tb/tb_sha_result_checker.sv
// -----------------------------------------------------------------------------
// tb_sha_result_checker
// Self-checking bench for sha_result_checker. A queue-based reference model
// works from the block's behavioural rules: the hash value is compared
// directly as a number, the target is built by repeated multiply/divide by
// 256, and the FIFO is a plain queue with a one-edge delay for stage 1.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_sha_result_checker;
    import sha_pkg::*;

    localparam int PI    = 2;
    localparam int NP    = 4;
    localparam int DEPTH = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         output_valid;
    logic         newblock_o;
    logic [255:0] doublehash;
    logic [31:0]  difficulty;
    logic         result_valid;
    logic         result_ready;
    logic [31:0]  result_nonce;
    logic [7:0]   result_epoch;
    logic         overflow;
    logic [31:0]  checked_count;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    sha_result_checker #(
        .PROCESSORINDEX (PI),
        .NUMPROCESSORS  (NP),
        .FIFO_DEPTH     (DEPTH)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .output_valid  (output_valid),
        .newblock_o    (newblock_o),
        .doublehash    (doublehash),
        .difficulty    (difficulty),
        .result_valid  (result_valid),
        .result_ready  (result_ready),
        .result_nonce  (result_nonce),
        .result_epoch  (result_epoch),
        .overflow      (overflow),
        .checked_count (checked_count)
    );

    // ---------------------------------------------------------------------
    // Reference model
    // ---------------------------------------------------------------------
    ResultEntry  mq[$];
    logic        pend_v;
    logic        pend_q;
    ResultEntry  pend_e;
    logic [7:0]  m_epoch;
    logic [31:0] m_next;
    logic [31:0] m_count;
    logic [31:0] m_last_nonce;
    logic        m_ovf;

    function automatic logic [255:0] model_target(input logic [31:0] d);
        int           e;
        logic [255:0] t;
        e = int'(d[31:24]);
        t = {232'd0, d[23:0]};
        if (e > 32) return '1;
        for (int i = e; i < 3; i++) t = t / 256'd256;
        for (int i = 3; i < e; i++) t = t * 256'd256;
        return t;
    endfunction

    // Bus carries H with its least significant byte first.
    function automatic logic [255:0] h_to_bus(input logic [255:0] h);
        logic [255:0] b;
        for (int k = 0; k < 32; k++) b[8*k +: 8] = h[255-8*k -: 8];
        return b;
    endfunction

    function automatic logic [255:0] rand_hash();
        logic [255:0] h;
        for (int k = 0; k < 8; k++) h[32*k +: 32] = $urandom;
        return h;
    endfunction

    task automatic model_reset();
        mq.delete();
        pend_v       = 1'b0;
        pend_q       = 1'b0;
        pend_e       = '0;
        m_epoch      = '0;
        m_next       = 32'(PI);
        m_count      = '0;
        m_last_nonce = '0;
        m_ovf        = 1'b0;
    endtask

    // Applies one clock edge to the model with the inputs held across it.
    task automatic model_edge(input logic v, input logic nb, input logic [255:0] h,
                              input logic [31:0] diff, input logic rdy);
        logic       pop;
        logic       drp;
        ResultEntry e;
        pop  = (mq.size() != 0) && rdy;
        drp  = pend_v && pend_q && (mq.size() == DEPTH) && !pop;
        m_ovf = drp;
        if (pop) void'(mq.pop_front());
        if (pend_v && pend_q && !drp) mq.push_back(pend_e);
        pend_v = v;
        pend_q = 1'b0;
        if (v) begin
            m_count = m_count + 32'd1;
            if (nb) begin
                m_epoch      = m_epoch + 8'd1;
                m_last_nonce = 32'(PI);
                m_next       = 32'(PI) + 32'(NP);
            end else begin
                m_last_nonce = m_next;
                m_next       = m_next + 32'(NP);
            end
            e.nonce = m_last_nonce;
            e.epoch = m_epoch;
            pend_e  = e;
            pend_q  = (h <= model_target(diff));
        end
    endtask

    // Drive one cycle of inputs, advance through the edge, return at negedge.
    task automatic step(input logic v, input logic nb, input logic [255:0] h,
                        input logic [31:0] diff, input logic rdy);
        output_valid = v;
        newblock_o   = nb;
        doublehash   = h_to_bus(h);
        difficulty   = diff;
        result_ready = rdy;
        @(posedge clk);
        model_edge(v, nb, h, diff, rdy);
        @(negedge clk);
    endtask

    // One isolated result followed by its observation two cycles later.
    task automatic send_one(input logic [255:0] h, input logic [31:0] diff,
                            output logic got_valid, output logic [31:0] got_nonce,
                            output logic [31:0] want_nonce);
        step(1'b1, 1'b0, h, diff, 1'b1);
        want_nonce = m_last_nonce;
        step(1'b0, 1'b0, '0, diff, 1'b1);
        got_valid = result_valid;
        got_nonce = result_nonce;
        step(1'b0, 1'b0, '0, diff, 1'b1);
    endtask

    // ---------------------------------------------------------------------
    // Tests
    // ---------------------------------------------------------------------
    task automatic test_reset();
        output_valid = 1'b0; newblock_o = 1'b0; doublehash = '0;
        difficulty = '0; result_ready = 1'b0;
        rst = 1'b1;
        model_reset();
        repeat (2) @(negedge clk);
        n_checks++; if (result_valid !== 1'b0) begin n_errors++; $display("FAIL reset_valid got %0b want 0", result_valid); end
        n_checks++; if (overflow !== 1'b0) begin n_errors++; $display("FAIL reset_overflow got %0b want 0", overflow); end
        n_checks++; if (checked_count !== 32'd0) begin n_errors++; $display("FAIL reset_count got %0d want 0", checked_count); end
        n_checks++; if (result_nonce !== 32'd0) begin n_errors++; $display("FAIL reset_nonce got %0h want 0", result_nonce); end
        n_checks++; if (result_epoch !== 8'd0) begin n_errors++; $display("FAIL reset_epoch got %0h want 0", result_epoch); end
        rst = 1'b0;
        step(1'b0, 1'b1, '0, 32'h2100FFFF, 1'b0);
        n_checks++; if (result_valid !== 1'b0 || checked_count !== 32'd0) begin
            n_errors++; $display("FAIL reset_newblock_ignored valid %0b count %0d want 0 0", result_valid, checked_count);
        end
    endtask

    task automatic test_first_nonce();
        for (int j = 0; j < 4; j++) begin
            step(1'b1, j == 0, rand_hash(), 32'h2100FFFF, 1'b0);
            if (j == 0) begin
                n_checks++; if (result_valid !== 1'b0) begin n_errors++; $display("FAIL first_latency_early got %0b want 0", result_valid); end
            end
            if (j == 1) begin
                n_checks++; if (result_valid !== 1'b1) begin n_errors++; $display("FAIL first_latency got %0b want 1", result_valid); end
            end
        end
        step(1'b0, 1'b0, '0, 32'h2100FFFF, 1'b0);
        n_checks++; if (checked_count !== 32'd4) begin n_errors++; $display("FAIL first_count got %0d want 4", checked_count); end
        for (int j = 0; j < 4; j++) begin
            n_checks++;
            if (result_valid !== 1'b1 || result_nonce !== 32'(PI + j*NP) || result_epoch !== 8'd1) begin
                n_errors++;
                $display("FAIL first_entry%0d got v%0b n%0d e%0d want v1 n%0d e1", j, result_valid, result_nonce, result_epoch, PI + j*NP);
            end
            step(1'b0, 1'b0, '0, 32'h2100FFFF, 1'b1);
        end
        n_checks++; if (result_valid !== 1'b0) begin n_errors++; $display("FAIL first_drained got %0b want 0", result_valid); end
    endtask

    task automatic test_genesis();
        logic [255:0] hs [3];
        logic         ok [3];
        logic         gv;
        logic [31:0]  gn, wn;
        hs[0] = {32'h0, 16'hFFFF, 208'h0};            ok[0] = 1'b1;
        hs[1] = {32'h0, 16'hFFFF, 208'h0} | 256'd1;   ok[1] = 1'b0;
        hs[2] = {32'h1, 224'h0};                      ok[2] = 1'b0;
        for (int i = 0; i < 3; i++) begin
            send_one(hs[i], 32'h1D00FFFF, gv, gn, wn);
            n_checks++;
            if (gv !== ok[i] || (ok[i] && gn !== wn)) begin
                n_errors++; $display("FAIL genesis%0d got v%0b n%0d want v%0b n%0d", i, gv, gn, ok[i], wn);
            end
        end
    endtask

    task automatic test_low_exponent();
        logic [255:0] hs [2];
        logic         ok [2];
        logic         gv;
        logic [31:0]  gn, wn;
        hs[0] = 256'h1234; ok[0] = 1'b1;
        hs[1] = 256'h1235; ok[1] = 1'b0;
        for (int i = 0; i < 2; i++) begin
            send_one(hs[i], 32'h02123456, gv, gn, wn);
            n_checks++;
            if (gv !== ok[i] || (ok[i] && gn !== wn)) begin
                n_errors++; $display("FAIL lowexp%0d got v%0b n%0d want v%0b n%0d", i, gv, gn, ok[i], wn);
            end
        end
    endtask

    task automatic test_overflow();
        logic [7:0] ep;
        ep = m_epoch + 8'd1;
        for (int s = 0; s < 8; s++) begin
            step(s < 6, s == 0, rand_hash(), 32'h2100FFFF, 1'b0);
            n_checks++;
            if (overflow !== ((s == 5) || (s == 6))) begin
                n_errors++; $display("FAIL overflow_cycle%0d got %0b want %0b", s, overflow, (s == 5) || (s == 6));
            end
        end
        for (int j = 0; j < 4; j++) begin
            n_checks++;
            if (result_valid !== 1'b1 || result_nonce !== 32'(PI + j*NP) || result_epoch !== ep) begin
                n_errors++;
                $display("FAIL overflow_pop%0d got v%0b n%0d e%0d want v1 n%0d e%0d", j, result_valid, result_nonce, result_epoch, PI + j*NP, ep);
            end
            step(1'b0, 1'b0, '0, 32'h2100FFFF, 1'b1);
        end
        step(1'b0, 1'b0, '0, 32'h2100FFFF, 1'b1);
        n_checks++; if (result_valid !== 1'b0) begin n_errors++; $display("FAIL overflow_extra_pop got %0b want 0", result_valid); end
    endtask

    task automatic test_full_push_pop();
        logic [31:0] sb[$];
        // Four entries land in the FIFO; the fifth waits in stage 1.
        for (int j = 0; j < 5; j++) begin
            step(1'b1, 1'b0, rand_hash(), 32'h2100FFFF, 1'b0);
            sb.push_back(m_last_nonce);
        end
        for (int c = 0; c < 16; c++) begin
            n_checks++;
            if (result_valid !== (mq.size() != 0) || overflow !== 1'b0) begin
                n_errors++; $display("FAIL fullpp_status%0d got v%0b o%0b want v%0b o0", c, result_valid, overflow, mq.size() != 0);
            end
            if (result_valid) begin
                n_checks++;
                if (sb.size() == 0 || result_nonce !== sb[0]) begin
                    n_errors++; $display("FAIL fullpp_order%0d got %0d want %0d", c, result_nonce, (sb.size() != 0) ? sb[0] : 32'hFFFFFFFF);
                end
                if (sb.size() != 0) void'(sb.pop_front());
            end
            step(c < 10, 1'b0, rand_hash(), 32'h2100FFFF, 1'b1);
            if (c < 10) sb.push_back(m_last_nonce);
        end
        n_checks++; if (sb.size() != 0 || result_valid !== 1'b0) begin
            n_errors++; $display("FAIL fullpp_leftover got %0d pending v%0b want 0 v0", sb.size(), result_valid);
        end
    endtask

    task automatic test_random();
        logic [31:0] diffs [8];
        logic        v, nb, rdy;
        diffs = '{32'h2100FFFF, 32'h1D00FFFF, 32'h20FFFFFF, 32'h1F00FFFF,
                  32'h02123456, 32'h03800000, 32'h22000001, 32'h00000000};
        for (int c = 0; c < 400; c++) begin
            v   = ($urandom % 4) != 0;
            nb  = ($urandom % 16) == 0;
            rdy = ($urandom % 2) != 0;
            step(v, nb, rand_hash() >> (8 * $urandom_range(0, 32)), diffs[$urandom % 8], rdy);
            n_checks++;
            if (result_valid !== (mq.size() != 0)) begin
                n_errors++; $display("FAIL rand_valid c%0d got %0b want %0b", c, result_valid, mq.size() != 0);
            end else if (result_valid && (result_nonce !== mq[0].nonce || result_epoch !== mq[0].epoch)) begin
                n_errors++; $display("FAIL rand_head c%0d got n%0d e%0d want n%0d e%0d", c, result_nonce, result_epoch, mq[0].nonce, mq[0].epoch);
            end
            n_checks++;
            if (overflow !== m_ovf || checked_count !== m_count) begin
                n_errors++; $display("FAIL rand_ovf_count c%0d got o%0b n%0d want o%0b n%0d", c, overflow, checked_count, m_ovf, m_count);
            end
        end
        repeat (DEPTH + 3) step(1'b0, 1'b0, '0, '0, 1'b1);
    endtask

    task automatic test_reset_mid_stream();
        for (int j = 0; j < 4; j++) step(1'b1, 1'b0, rand_hash(), 32'h2100FFFF, 1'b0);
        n_checks++; if (mq.size() != 3 || result_valid !== 1'b1) begin
            n_errors++; $display("FAIL midrst_setup got model %0d v%0b want 3 v1", mq.size(), result_valid);
        end
        output_valid = 1'b1;
        doublehash   = h_to_bus(rand_hash());
        #2 rst = 1'b1;
        #1;
        model_reset();
        n_checks++; if (result_valid !== 1'b0) begin n_errors++; $display("FAIL midrst_valid_drop got %0b want 0", result_valid); end
        n_checks++; if (checked_count !== 32'd0) begin n_errors++; $display("FAIL midrst_count got %0d want 0", checked_count); end
        output_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 6; c++) begin
            step(1'b0, 1'b0, '0, 32'h2100FFFF, 1'b1);
            n_checks++; if (result_valid !== 1'b0) begin n_errors++; $display("FAIL midrst_ghost%0d got %0b want 0", c, result_valid); end
        end
        step(1'b1, 1'b1, rand_hash(), 32'h2100FFFF, 1'b0);
        step(1'b0, 1'b0, '0, 32'h2100FFFF, 1'b0);
        n_checks++;
        if (result_valid !== 1'b1 || result_nonce !== 32'(PI) || result_epoch !== 8'd1) begin
            n_errors++; $display("FAIL midrst_restart got v%0b n%0d e%0d want v1 n%0d e1", result_valid, result_nonce, result_epoch, PI);
        end
        step(1'b0, 1'b0, '0, 32'h2100FFFF, 1'b1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_first_nonce();
        test_genesis();
        test_low_exponent();
        test_overflow();
        test_full_push_pop();
        test_random();
        test_reset_mid_stream();
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
